branch_cmp: RTL
===============

BRANCH_CMP -- requirements
Module: branch_cmp

Interface
REQ-001 Parameter XLEN, default 32: operand width in bits.
REQ-002 Parameter CHUNK, default 8: bits compared per scan cycle; XLEN SHALL be an integer multiple of CHUNK; N = XLEN/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand pair presented.
REQ-006 in_ready  output  1  block accepts an operand pair.
REQ-007 rs1  input  XLEN  first operand.
REQ-008 rs2  input  XLEN  second operand.
REQ-009 flush  input  1  synchronous abort of any compare in progress.
REQ-010 out_valid  output  1  flags valid.
REQ-011 out_ready  input  1  consumer (branch decision unit) takes the flags.
REQ-012 eq  output  1  rs1 == rs2.
REQ-013 ge  output  1  rs1 >= rs2, signed.
REQ-014 less  output  1  rs1 < rs2, signed.
REQ-015 ge_u  output  1  rs1 >= rs2, unsigned.
REQ-016 less_u  output  1  rs1 < rs2, unsigned.

Function
REQ-017 States IDLE, SCAN, DONE. in_ready SHALL be 1 only in IDLE, derived from state alone.
REQ-018 IDLE: in_valid && in_ready at an edge SHALL capture rs1/rs2, load chunk index N-1, and enter SCAN.
REQ-019 SCAN: each cycle compares chunk [idx*CHUNK +: CHUNK] of the captured operands, MSB chunk first.
REQ-020 First differing chunk: less_u = (chunk1 < chunk2); flags registered; enter DONE on that edge (early exit).
REQ-021 Chunk equal and idx == 0: eq = 1, less_u = 0; enter DONE. Otherwise idx decrements and the block stays in SCAN.
REQ-022 Signed result: sign bits differ -> less = rs1[XLEN-1]; otherwise less = less_u. ge = !less; ge_u = !less_u.
REQ-023 Latency: out_valid SHALL rise k edges after the accept edge; k = 1-based position of the first differing chunk counted from the MSB, or N if the operands are equal.
REQ-024 DONE: out_valid = 1; all five flags SHALL remain stable until out_valid && out_ready; that edge returns to IDLE and clears out_valid.
REQ-025 in_valid outside IDLE SHALL be ignored; operands SHALL not be re-sampled.
REQ-026 flush SHALL dominate all other inputs: the next state is IDLE, out_valid = 0 and flags = 0, including when flush coincides with an accept or the output handshake.
REQ-027 Exactly one of eq/less_u SHALL be able to be 1 when out_valid = 1; ge_u == !less_u and ge == !less SHALL hold whenever out_valid = 1.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, out_valid = 0, eq = ge = less = ge_u = less_u = 0, in_ready = 1, and clear the captured operands and index, independent of clk.
REQ-029 Reset asserted mid-SCAN or in DONE SHALL discard the in-flight compare; no out_valid SHALL follow reset release.

Configuration
REQ-030 Macro BRANCH_CMP_FAST_EN defined: SCAN SHALL compare the full XLEN word in one cycle; latency SHALL always be 1 edge; the index counter SHALL be absent.
REQ-031 BRANCH_CMP_FAST_EN undefined: chunked scan per REQ-019..REQ-023. All interface and handshake behaviour SHALL be identical in both builds.

Verification
REQ-032 rs1 = 0x00000005, rs2 = 0x00000005 -> out_valid after 4 edges; eq = 1, ge = 1, ge_u = 1, less = 0, less_u = 0.
REQ-033 rs1 = 0xFFFFFFFF, rs2 = 0x00000001 -> out_valid after 1 edge; less = 1, ge = 0, less_u = 0, ge_u = 1, eq = 0.
REQ-034 rs1 = 0x00000010, rs2 = 0x00000020 -> out_valid after 4 edges; less = 1, less_u = 1, eq = 0. With BRANCH_CMP_FAST_EN: same flags after 1 edge.
REQ-035 Result in DONE, out_ready held 0 for 3 cycles, in_valid = 1 with new operands -> flags and out_valid stable, in_ready = 0, new operands not captured; out_ready = 1 -> IDLE next edge.
REQ-036 flush = 1 on the second SCAN cycle of rs1 = 0x12000000, rs2 = 0x12000001 -> IDLE on the next edge, in_ready = 1, out_valid never asserted.
REQ-037 rst_n pulsed low mid-SCAN between clock edges -> outputs zero and in_ready = 1 immediately; no out_valid after release.

Source files
------------

// File: rtl/branch_cmp.sv
// ---------------------------------------------------------------------------
// branch_cmp
//
// Multi-cycle comparator producing the five RISC-V style branch flags for an
// operand pair. Operands are captured on an in_valid/in_ready handshake, then
// scanned CHUNK bits at a time starting from the most significant chunk; the
// scan stops at the first differing chunk, so latency depends on where the
// operands first differ. Results are held until out_valid/out_ready.
//
// Optional build: define BRANCH_CMP_FAST_EN to compare the whole word in a
// single SCAN cycle (latency always 1, no chunk index counter).
//
// Parameters
//   XLEN   operand width in bits
//   CHUNK  bits compared per scan cycle (XLEN must be a multiple of CHUNK)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair presented
//   in_ready   block is idle and accepts an operand pair
//   rs1, rs2   operands
//   flush      synchronous abort; dominates every other input
//   out_valid  flags valid
//   out_ready  consumer takes the flags
//   eq         rs1 == rs2
//   ge, less   signed rs1 >= rs2 / rs1 < rs2
//   ge_u       unsigned rs1 >= rs2
//   less_u     unsigned rs1 < rs2
// ---------------------------------------------------------------------------
module branch_cmp #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            eq,
    output logic            ge,
    output logic            less,
    output logic            ge_u,
    output logic            less_u
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg,  state_next;
    logic [XLEN-1:0] rs1_reg,    rs1_next;
    logic [XLEN-1:0] rs2_reg,    rs2_next;
    logic            eq_reg,     eq_next;
    logic            less_reg,   less_next;
    logic            less_u_reg, less_u_next;

    // Sign bits of the captured operands. When they differ the signed order
    // is decided by the sign alone; otherwise it equals the unsigned order.
    logic sign_differs;
    assign sign_differs = rs1_reg[XLEN-1] ^ rs2_reg[XLEN-1];

`ifndef BRANCH_CMP_FAST_EN
    localparam int N     = XLEN / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] idx_reg, idx_next;

    // Chunk views of the captured operands, selected by the scan index.
    logic [CHUNK-1:0] chunks1 [N];
    logic [CHUNK-1:0] chunks2 [N];
    logic [CHUNK-1:0] chunk1;
    logic [CHUNK-1:0] chunk2;

    for (genvar gi = 0; gi < N; gi++) begin : g_chunk
        assign chunks1[gi] = rs1_reg[gi*CHUNK +: CHUNK];
        assign chunks2[gi] = rs2_reg[gi*CHUNK +: CHUNK];
    end

    assign chunk1 = chunks1[idx_reg];
    assign chunk2 = chunks2[idx_reg];
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            rs1_reg    <= '0;
            rs2_reg    <= '0;
            eq_reg     <= 1'b0;
            less_reg   <= 1'b0;
            less_u_reg <= 1'b0;
`ifndef BRANCH_CMP_FAST_EN
            idx_reg    <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            rs1_reg    <= rs1_next;
            rs2_reg    <= rs2_next;
            eq_reg     <= eq_next;
            less_reg   <= less_next;
            less_u_reg <= less_u_next;
`ifndef BRANCH_CMP_FAST_EN
            idx_reg    <= idx_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        rs1_next    = rs1_reg;
        rs2_next    = rs2_reg;
        eq_next     = eq_reg;
        less_next   = less_reg;
        less_u_next = less_u_reg;
`ifndef BRANCH_CMP_FAST_EN
        idx_next    = idx_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    rs1_next   = rs1;
                    rs2_next   = rs2;
`ifndef BRANCH_CMP_FAST_EN
                    idx_next   = IDX_W'(N - 1);
`endif
                    state_next = SCAN;
                end
            end

            SCAN: begin
`ifdef BRANCH_CMP_FAST_EN
                eq_next     = (rs1_reg == rs2_reg);
                less_u_next = (rs1_reg <  rs2_reg);
                less_next   = sign_differs ? rs1_reg[XLEN-1]
                                           : (rs1_reg < rs2_reg);
                state_next  = DONE;
`else
                if (chunk1 != chunk2) begin
                    // First difference from the top decides the order.
                    eq_next     = 1'b0;
                    less_u_next = (chunk1 < chunk2);
                    less_next   = sign_differs ? rs1_reg[XLEN-1]
                                               : (chunk1 < chunk2);
                    state_next  = DONE;
                end else if (idx_reg == '0) begin
                    eq_next     = 1'b1;
                    less_u_next = 1'b0;
                    less_next   = 1'b0;
                    state_next  = DONE;
                end else begin
                    idx_next    = idx_reg - IDX_W'(1);
                end
`endif
            end

            DONE: begin
                if (out_ready) begin
                    eq_next     = 1'b0;
                    less_next   = 1'b0;
                    less_u_next = 1'b0;
                    state_next  = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort wins over accept, scan progress and the output handshake.
        if (flush) begin
            state_next  = IDLE;
            rs1_next    = rs1_reg;
            rs2_next    = rs2_reg;
            eq_next     = 1'b0;
            less_next   = 1'b0;
            less_u_next = 1'b0;
`ifndef BRANCH_CMP_FAST_EN
            idx_next    = idx_reg;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The ge flags are the complements of the less flags only
    // while a result is presented, so they read 0 otherwise.
    // ------------------------------------------------------------------
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign eq        = eq_reg;
    assign less      = less_reg;
    assign less_u    = less_u_reg;
    assign ge        = out_valid & ~less_reg;
    assign ge_u      = out_valid & ~less_u_reg;

endmodule
